tty_writer: RTL and testbench
=============================

TTY_WRITER -- requirements
Module: tty_writer

Interface
REQ-001 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning that when it is 1 the whole text buffer is blanked after reset.
REQ-002 The block SHALL have port clk_data, input, width 1: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rstn, input, width 1: asynchronous active-low reset.
REQ-004 The block SHALL have port rx_data, input, width 8: character byte.
REQ-005 The block SHALL have port rx_valid, input, width 1: rx_data valid.
REQ-006 The block SHALL have port rx_ready, output, width 1: byte accepted when rx_valid && rx_ready.
REQ-007 The block SHALL have port attr_fg, input, width 4: foreground colour index, sampled at acceptance.
REQ-008 The block SHALL have port attr_bg, input, width 3: background colour index, sampled at acceptance.
REQ-009 The block SHALL have port addrb, output, width 12: display port address; bit 11=0 selects buffer word, bit 11=1 selects register.
REQ-010 The block SHALL have port dinb, output, width 64: display port write data.
REQ-011 The block SHALL have port web, output, width 8: display port byte write enables.
REQ-012 The block SHALL have port enb, output, width 1: display port enable; it is high exactly on write cycles.
REQ-013 The block SHALL have port busy, output, width 1: high in every state except IDLE.

Function
REQ-014 The screen SHALL be 128 columns x 32 physical rows; cell index = {prow[4:0], col[6:0]}; buffer word = cell index >> 2; lane = col[1:0].
REQ-015 The cell format SHALL be [15]=0, [14:12]=bg, [11:8]=fg, [7:0]=ASCII; a blank cell is {0, bg, fg, 8'h20}.
REQ-016 A cell write SHALL drive addrb={0, word[10:0]}, dinb=cell replicated into all four 16-bit lanes, and web=8'b11 << (2*lane).
REQ-017 A register write SHALL drive addrb=12'h800|sel, dinb[6:0]=value with other bits 0, and web=8'h01; sel 0=scroll (value {2'b0,top}), sel 2=xcursor (col), sel 3=ycursor ({2'b0,prow}).
REQ-018 The state SHALL be col[6:0], line[4:0] (logical, 0..31), top[4:0] (physical row of line 0), and prow=(top+line) mod 32.
REQ-019 The FSM states SHALL be CLR_ALL, IDLE, WR_CHAR, CLR_ROW, WR_SCROLL, WR_XCUR, WR_YCUR, with one port write per cycle in every non-IDLE state and no backpressure.
REQ-020 rx_ready SHALL be high only in IDLE; an accepted byte is decoded in the same cycle.
REQ-021 Bytes 0x20-0x7E SHALL go to WR_CHAR, which writes the cell at (prow, col) in the cycle after acceptance; then col=col+1, and if col was 127, col=0 and a newline is performed.
REQ-022 Byte 0x0D SHALL set col=0. Byte 0x0A SHALL set col=0 and perform a newline. Byte 0x08 SHALL decrement col if col>0, with no write and no line change at col=0. Byte 0x09 SHALL set col to the next multiple of 8; crossing 127 gives col=0 and a newline. Each of these SHALL go to WR_XCUR.
REQ-023 All other bytes SHALL be consumed with no write, staying in IDLE.
REQ-024 Newline with line<31 SHALL set line=line+1 then go to WR_XCUR.
REQ-025 Newline with line==31 SHALL set top=top+1 mod 32, keep line=31, then go to CLR_ROW: 32 consecutive cycles writing word {newprow, k[4:0]}, k=0..31, with web=8'hFF and four blank cells; then WR_SCROLL; then WR_XCUR.
REQ-026 The sequence WR_XCUR -> WR_YCUR -> IDLE SHALL always follow, so the cursor registers match col/prow before the next byte is accepted.
REQ-027 Latency for a printable char without newline SHALL be: accept cycle, then WR_CHAR, WR_XCUR, WR_YCUR; rx_ready is high again on the fourth cycle after acceptance.
REQ-028 Attributes captured at acceptance SHALL be used for the char write and any CLR_ROW it triggers.

Reset
REQ-029 While rstn=0: col=0, line=0, top=0, rx_ready=0, enb=0, web=0, addrb=0, dinb=0; busy=1 if CLEAR_ON_RESET, else busy=0.
REQ-030 After rstn rises with CLEAR_ON_RESET=1, CLR_ALL SHALL write words 0..1023 with web=8'hFF and blank cells (fg=7, bg=0, i.e. 16'h0720), one per cycle, then go to WR_SCROLL (0), WR_XCUR (0), WR_YCUR (0), IDLE.
REQ-031 After rstn rises with CLEAR_ON_RESET=0, the block SHALL enter IDLE directly with no writes.
REQ-032 Reset asserted mid-sequence SHALL abort immediately; no partial sequence resumes.

Verification
REQ-033 Reset release, CLEAR_ON_RESET=1 -> exactly 1024 writes of 64'h0720072007200720 to addresses 0..1023, then writes to 0x800=0, 0x802=0, 0x803=0, then rx_ready=1.
REQ-034 'A' (0x41), fg=0xE, bg=1, at col 5 line 0 top 0 -> addrb=1, web=8'h0C, dinb[31:16]=16'h1E41; xcursor=6, ycursor=0.
REQ-035 128 printable chars from col 0, line 3 -> last write at col 127 (web=8'hC0), then xcursor=0, ycursor=4.
REQ-036 LF at line 31, top 0 -> 32 writes to words 0x000-0x01F with web=8'hFF; scroll register=1; xcursor=0; ycursor=0.
REQ-037 BS at col 0, then TAB at col 125 -> BS: xcursor=0, no cell write; TAB: col=0 and line+1.
REQ-038 rstn pulsed low during CLR_ROW k=10 -> enb=0 immediately, then CLR_ALL restarts from word 0.

Source files
------------

// File: rtl/tty_writer.sv
// tty_writer: turns a stream of character bytes into writes on a 64-bit
// display port. The port holds a 128x32 text buffer of 16-bit cells, four
// cells per word, plus scroll and cursor registers. The display is scrolled
// by moving the physical row that is shown as logical line 0.
module tty_writer #(
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk_data,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [3:0]  attr_fg,
    input  logic [2:0]  attr_bg,
    output logic [11:0] addrb,
    output logic [63:0] dinb,
    output logic [7:0]  web,
    output logic        enb,
    output logic        busy
);

    typedef enum logic [2:0] {
        CLR_ALL,
        IDLE,
        WR_CHAR,
        CLR_ROW,
        WR_SCROLL,
        WR_XCUR,
        WR_YCUR
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_ALL : IDLE;

    state_t      r_state;
    logic [6:0]  r_col;
    logic [4:0]  r_line;
    logic [4:0]  r_top;
    logic [9:0]  r_k;
    logic [7:0]  r_ch;
    logic [3:0]  r_fg;
    logic [2:0]  r_bg;

    state_t      w_stateNext;
    logic [6:0]  w_colNext;
    logic [4:0]  w_lineNext;
    logic [4:0]  w_topNext;
    logic [9:0]  w_kNext;
    logic [7:0]  w_chNext;
    logic [3:0]  w_fgNext;
    logic [2:0]  w_bgNext;
    logic        w_newline;
    logic        w_toXcur;

    logic [4:0]  w_prow;
    logic [15:0] w_charCell;
    logic [15:0] w_blankCell;

    assign w_prow      = r_top + r_line;
    assign w_charCell  = {1'b0, r_bg, r_fg, r_ch};
    assign w_blankCell = {1'b0, r_bg, r_fg, 8'h20};

    // State and cursor registers; reset drops any sequence in progress.
    always_ff @(posedge clk_data or negedge rstn) begin
        if (!rstn) begin
            r_state <= RESET_STATE;
            r_col   <= 7'd0;
            r_line  <= 5'd0;
            r_top   <= 5'd0;
            r_k     <= 10'd0;
            r_ch    <= 8'h20;
            r_fg    <= 4'd7;
            r_bg    <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_col   <= w_colNext;
            r_line  <= w_lineNext;
            r_top   <= w_topNext;
            r_k     <= w_kNext;
            r_ch    <= w_chNext;
            r_fg    <= w_fgNext;
            r_bg    <= w_bgNext;
        end
    end

    // Byte decode, cursor movement and sequencing; a newline either moves
    // down a line or, on the last line, scrolls and blanks the new row.
    always_comb begin
        w_stateNext = r_state;
        w_colNext   = r_col;
        w_lineNext  = r_line;
        w_topNext   = r_top;
        w_kNext     = r_k;
        w_chNext    = r_ch;
        w_fgNext    = r_fg;
        w_bgNext    = r_bg;
        w_newline   = 1'b0;
        w_toXcur    = 1'b0;

        case (r_state)
            CLR_ALL: begin
                w_kNext = r_k + 10'd1;
                if (r_k == 10'd1023) begin
                    w_kNext     = 10'd0;
                    w_stateNext = WR_SCROLL;
                end
            end
            IDLE: begin
                if (rx_valid) begin
                    w_fgNext = attr_fg;
                    w_bgNext = attr_bg;
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        w_chNext    = rx_data;
                        w_stateNext = WR_CHAR;
                    end else begin
                        case (rx_data)
                            8'h0D: begin
                                w_colNext = 7'd0;
                                w_toXcur  = 1'b1;
                            end
                            8'h0A: begin
                                w_colNext = 7'd0;
                                w_newline = 1'b1;
                            end
                            8'h08: begin
                                if (r_col != 7'd0) begin
                                    w_colNext = r_col - 7'd1;
                                end
                                w_toXcur = 1'b1;
                            end
                            8'h09: begin
                                if (r_col[6:3] == 4'hF) begin
                                    w_colNext = 7'd0;
                                    w_newline = 1'b1;
                                end else begin
                                    w_colNext = {r_col[6:3] + 4'd1, 3'b000};
                                    w_toXcur  = 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            WR_CHAR: begin
                if (r_col == 7'd127) begin
                    w_colNext = 7'd0;
                    w_newline = 1'b1;
                end else begin
                    w_colNext = r_col + 7'd1;
                    w_toXcur  = 1'b1;
                end
            end
            CLR_ROW: begin
                w_kNext = r_k + 10'd1;
                if (r_k[4:0] == 5'd31) begin
                    w_kNext     = 10'd0;
                    w_stateNext = WR_SCROLL;
                end
            end
            WR_SCROLL: w_stateNext = WR_XCUR;
            WR_XCUR:   w_stateNext = WR_YCUR;
            WR_YCUR:   w_stateNext = IDLE;
            default:   w_stateNext = IDLE;
        endcase

        if (w_toXcur) begin
            w_stateNext = WR_XCUR;
        end
        if (w_newline) begin
            if (r_line != 5'd31) begin
                w_lineNext  = r_line + 5'd1;
                w_stateNext = WR_XCUR;
            end else begin
                w_topNext   = r_top + 5'd1;
                w_kNext     = 10'd0;
                w_stateNext = CLR_ROW;
            end
        end
    end

    // Display port drive: exactly one write per non-idle cycle, silent in reset.
    always_comb begin
        enb   = 1'b0;
        web   = 8'h00;
        addrb = 12'h000;
        dinb  = 64'd0;
        if (rstn) begin
            case (r_state)
                CLR_ALL: begin
                    enb   = 1'b1;
                    web   = 8'hFF;
                    addrb = {2'b00, r_k};
                    dinb  = {4{16'h0720}};
                end
                WR_CHAR: begin
                    enb   = 1'b1;
                    web   = 8'b0000_0011 << {r_col[1:0], 1'b0};
                    addrb = {2'b00, w_prow, r_col[6:2]};
                    dinb  = {4{w_charCell}};
                end
                CLR_ROW: begin
                    enb   = 1'b1;
                    web   = 8'hFF;
                    addrb = {2'b00, w_prow, r_k[4:0]};
                    dinb  = {4{w_blankCell}};
                end
                WR_SCROLL: begin
                    enb   = 1'b1;
                    web   = 8'h01;
                    addrb = 12'h800;
                    dinb  = {59'd0, r_top};
                end
                WR_XCUR: begin
                    enb   = 1'b1;
                    web   = 8'h01;
                    addrb = 12'h802;
                    dinb  = {57'd0, r_col};
                end
                WR_YCUR: begin
                    enb   = 1'b1;
                    web   = 8'h01;
                    addrb = 12'h803;
                    dinb  = {59'd0, w_prow};
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and status flags.
    always_comb begin
        rx_ready = rstn && (r_state == IDLE);
        busy     = (r_state != IDLE);
    end

endmodule

// File: tb/tb_tty_writer.sv
// Directed bench for tty_writer: drives bytes, logs every display-port write
// and compares against hand-worked expectations.
module tb_tty_writer;

    logic        clk_data = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  attr_fg;
    logic [2:0]  attr_bg;
    logic        rx_ready;
    logic [11:0] addrb;
    logic [63:0] dinb;
    logic [7:0]  web;
    logic        enb;
    logic        busy;

    logic        rx_ready2;
    logic [11:0] addrb2;
    logic [63:0] dinb2;
    logic [7:0]  web2;
    logic        enb2;
    logic        busy2;

    int checks = 0;
    int failures = 0;

    logic [11:0] logAddr[$];
    logic [7:0]  logWeb[$];
    logic [63:0] logDin[$];
    logic [6:0]  scrollReg = 7'h7F;
    logic [6:0]  xReg = 7'h7F;
    logic [6:0]  yReg = 7'h7F;

    always #5 clk_data = ~clk_data;

    tty_writer #(.CLEAR_ON_RESET(1)) dut (
        .clk_data(clk_data), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .attr_fg(attr_fg), .attr_bg(attr_bg), .addrb(addrb),
        .dinb(dinb), .web(web), .enb(enb), .busy(busy)
    );

    tty_writer #(.CLEAR_ON_RESET(0)) dutNoClr (
        .clk_data(clk_data), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready2), .attr_fg(attr_fg), .attr_bg(attr_bg), .addrb(addrb2),
        .dinb(dinb2), .web(web2), .enb(enb2), .busy(busy2)
    );

    // Write logger and shadow copies of the display registers.
    always @(negedge clk_data) begin
        if (enb === 1'b1) begin
            logAddr.push_back(addrb);
            logWeb.push_back(web);
            logDin.push_back(dinb);
            if (addrb[11]) begin
                case (addrb[1:0])
                    2'd0: scrollReg = dinb[6:0];
                    2'd2: xReg = dinb[6:0];
                    2'd3: yReg = dinb[6:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        logAddr.delete();
        logWeb.delete();
        logDin.delete();
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (n < 3000) begin
            @(negedge clk_data);
            n++;
            if (rx_ready === 1'b1) break;
        end
        if (rx_ready !== 1'b1) checkOutput("timeout_ready", 64'd0, 64'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic [3:0] fg,
                                 input logic [2:0] bg, output int lat);
        @(negedge clk_data);
        rx_data  = b;
        attr_fg  = fg;
        attr_bg  = bg;
        rx_valid = 1'b1;
        @(posedge clk_data);
        #1 rx_valid = 1'b0;
        waitReady(lat);
    endtask

    initial begin
        int lat;
        int bad;
        int cellCount;
        logic [11:0] lastCellAddr;
        logic [7:0]  lastCellWeb;
        logic [63:0] word;

        rstn = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        attr_fg = 4'd7;
        attr_bg = 3'd0;

        // Reset state
        repeat (3) @(posedge clk_data);
        #2;
        checkOutput("rst_rx_ready", rx_ready, 0);
        checkOutput("rst_enb", enb, 0);
        checkOutput("rst_web", web, 0);
        checkOutput("rst_addrb", addrb, 0);
        checkOutput("rst_dinb", dinb, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_busy_noclr", busy2, 0);
        checkOutput("rst_ready_noclr", rx_ready2, 0);

        clearLog();
        rstn = 1'b1;
        @(negedge clk_data);
        checkOutput("noclr_ready", rx_ready2, 1);
        checkOutput("noclr_enb", enb2, 0);
        checkOutput("clr_busy", busy, 1);
        waitReady(lat);

        // Full clear after reset
        checkOutput("clrall_count", logAddr.size(), 1027);
        if (logAddr.size() >= 1027) begin
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                if (logAddr[i] !== 12'(i) || logWeb[i] !== 8'hFF ||
                    logDin[i] !== 64'h0720072007200720) bad++;
            end
            checkOutput("clrall_words", bad, 0);
            checkOutput("clrall_scroll_addr", logAddr[1024], 12'h800);
            checkOutput("clrall_xcur_addr", logAddr[1025], 12'h802);
            checkOutput("clrall_ycur_addr", logAddr[1026], 12'h803);
            checkOutput("clrall_ycur_data", logDin[1026], 0);
        end
        checkOutput("clrall_ready", rx_ready, 1);

        // 'A' at col 5 line 0
        for (int i = 0; i < 5; i++) applyStimulus(8'h20, 4'd7, 3'd0, lat);
        clearLog();
        applyStimulus(8'h41, 4'hE, 3'd1, lat);
        checkOutput("charA_latency", lat, 4);
        checkOutput("charA_count", logAddr.size(), 3);
        if (logAddr.size() >= 1) begin
            word = logDin[0];
            checkOutput("charA_addr", logAddr[0], 12'h001);
            checkOutput("charA_web", logWeb[0], 8'h0C);
            checkOutput("charA_lane", word[31:16], 16'h1E41);
        end
        checkOutput("charA_x", xReg, 6);
        checkOutput("charA_y", yReg, 0);

        // Ignored control byte
        clearLog();
        applyStimulus(8'h01, 4'd7, 3'd0, lat);
        checkOutput("ignored_writes", logAddr.size(), 0);
        checkOutput("ignored_latency", lat, 1);

        // Carriage return
        applyStimulus(8'h0D, 4'd7, 3'd0, lat);
        checkOutput("cr_x", xReg, 0);

        // 128 printable characters from col 0, line 3
        for (int i = 0; i < 3; i++) applyStimulus(8'h0A, 4'd7, 3'd0, lat);
        checkOutput("lf3_y", yReg, 3);
        clearLog();
        for (int i = 0; i < 128; i++) applyStimulus(8'h61, 4'd2, 3'd0, lat);
        cellCount = 0;
        lastCellAddr = 12'hFFF;
        lastCellWeb = 8'h00;
        foreach (logAddr[i]) begin
            if (!logAddr[i][11]) begin
                cellCount++;
                lastCellAddr = logAddr[i];
                lastCellWeb = logWeb[i];
            end
        end
        checkOutput("row_cells", cellCount, 128);
        checkOutput("row_last_addr", lastCellAddr, 12'h07F);
        checkOutput("row_last_web", lastCellWeb, 8'hC0);
        checkOutput("row_x", xReg, 0);
        checkOutput("row_y", yReg, 4);

        // Backspace at col 0
        clearLog();
        applyStimulus(8'h08, 4'd7, 3'd0, lat);
        checkOutput("bs0_writes", logAddr.size(), 2);
        checkOutput("bs0_x", xReg, 0);
        checkOutput("bs0_y", yReg, 4);

        // Tab at col 125 wraps to next line
        for (int i = 0; i < 125; i++) applyStimulus(8'h20, 4'd7, 3'd0, lat);
        checkOutput("col125_x", xReg, 125);
        clearLog();
        applyStimulus(8'h09, 4'd7, 3'd0, lat);
        checkOutput("tabwrap_writes", logAddr.size(), 2);
        checkOutput("tabwrap_x", xReg, 0);
        checkOutput("tabwrap_y", yReg, 5);
        applyStimulus(8'h09, 4'd7, 3'd0, lat);
        checkOutput("tab_x", xReg, 8);
        applyStimulus(8'h08, 4'd7, 3'd0, lat);
        checkOutput("bs_x", xReg, 7);

        // Reach the last line, then scroll
        for (int i = 0; i < 26; i++) applyStimulus(8'h0A, 4'd7, 3'd0, lat);
        checkOutput("line31_y", yReg, 31);
        clearLog();
        applyStimulus(8'h0A, 4'd3, 3'd2, lat);
        checkOutput("scroll_count", logAddr.size(), 35);
        if (logAddr.size() >= 35) begin
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                if (logAddr[i] !== 12'(i) || logWeb[i] !== 8'hFF ||
                    logDin[i] !== 64'h2320232023202320) bad++;
            end
            checkOutput("scroll_rows", bad, 0);
            checkOutput("scroll_reg_addr", logAddr[32], 12'h800);
        end
        checkOutput("scroll_val", scrollReg, 1);
        checkOutput("scroll_x", xReg, 0);
        checkOutput("scroll_y", yReg, 0);

        // Reset in the middle of a row clear
        clearLog();
        @(negedge clk_data);
        rx_data = 8'h0A;
        rx_valid = 1'b1;
        @(posedge clk_data);
        #1 rx_valid = 1'b0;
        lat = 0;
        while (logAddr.size() < 11 && lat < 100) begin
            @(negedge clk_data);
            #1;
            lat++;
        end
        checkOutput("abort_reached", logAddr.size(), 11);
        if (logAddr.size() >= 11) checkOutput("abort_k10_addr", logAddr[10], 12'd42);
        rstn = 1'b0;
        #1;
        checkOutput("abort_enb", enb, 0);
        checkOutput("abort_busy", busy, 1);
        checkOutput("abort_ready", rx_ready, 0);
        clearLog();
        @(posedge clk_data);
        @(posedge clk_data);
        #2 rstn = 1'b1;
        waitReady(lat);
        checkOutput("restart_count", logAddr.size(), 1027);
        if (logAddr.size() >= 1) checkOutput("restart_first", logAddr[0], 0);
        checkOutput("restart_scroll", scrollReg, 0);
        checkOutput("restart_y", yReg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
